dec2bin: RTL and testbench
==========================

Name: dec2bin

Overview:
Sequential BCD-to-binary converter, the inverse of the binary-to-BCD display path. It accepts a two-digit decimal value one digit at a time, over the same i_dec/i_tens/i_ones digit interface the display side uses. It converts the value to 6-bit binary with a multi-cycle reverse double-dabble (shift right, subtract 3). It is used for loading decimal setpoints, e.g. a temperature threshold, entered digit-by-digit from the IO pins.

Parameters:
BLANK_CODE, 4'd10, digit code meaning "blank"; converted as value 0.

Ports:
i_clk      input   1  system clock; all state on rising edge
i_reset_n  input   1  asynchronous active-low reset
i_dec      input   4  BCD digit (0-9), BLANK_CODE, or invalid (11-15)
i_tens     input   1  strobe: capture i_dec as tens digit
i_ones     input   1  strobe: capture i_dec as ones digit and start conversion
o_bin      output  6  converted binary result, held until next o_valid
o_valid    output  1  one-cycle pulse: o_bin/o_ovf/o_err updated
o_busy     output  1  high while conversion in progress
o_ovf      output  1  value > 63; o_bin saturated to 63
o_err      output  1  an invalid digit (11-15) was captured; o_bin forced 0

Behaviour:
- Reset (async, i_reset_n=0): o_bin=0, o_valid=0, o_busy=0, o_ovf=0, o_err=0, tens reg=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, CONV.
- IDLE, i_tens=1: tens reg <= i_dec.
  - BLANK_CODE is stored as 0.
  - 11-15 sets an internal err flag; 0 is stored.
- IDLE, i_ones=1 and i_tens=0: capture the ones digit with the same blank/err rules.
  - Load the 15-bit shift reg {tens[3:0], ones[3:0], bin[6:0]=0}.
  - counter <= 0; FSM -> CONV; o_busy <= 1.
- Simultaneous i_tens and i_ones in IDLE: i_tens wins; i_ones is ignored (no conversion starts).
- CONV, each cycle:
  - Shift the whole register right by 1.
  - Then, for each BCD nibble, if the nibble is >= 8, subtract 3.
  - counter++.
- After the 7th shift (counter==6 at that edge):
  - FSM -> IDLE; o_busy <= 0; o_valid <= 1 for exactly one cycle.
  - o_bin update: if err, o_bin <= 0, o_err <= 1, o_ovf <= 0. Else if bin[6]=1, o_bin <= 63, o_ovf <= 1, o_err <= 0. Else o_bin <= bin[5:0], o_ovf <= 0, o_err <= 0.
  - Tens reg and internal err flag clear to 0, so a following ones-only entry is a single-digit value.
- Latency: i_ones sampled at edge E0 -> o_valid high after edge E7 (7 cycles); o_busy high from E0 to E7.
- i_tens/i_ones while o_busy=1: ignored entirely; no state change and no queueing.
- o_bin/o_ovf/o_err hold their values between o_valid pulses.
- o_valid is a registered output; no combinational path from inputs to outputs.
- Reset asserted mid-CONV: immediate abort; all outputs go to reset values; no o_valid.
- After the 7th shift the BCD field is 0 for valid inputs. Checking this is not required in RTL, but verification checks it via hierarchy.

Test Plan:
- tens=4, ones=2 -> o_busy high for 7 cycles, then o_valid pulse with o_bin=42, o_ovf=0, o_err=0.
- tens=6,ones=3 -> o_bin=63, o_ovf=0; then tens=6,ones=4 -> o_bin=63, o_ovf=1; tens=9,ones=9 -> o_bin=63, o_ovf=1.
- tens=BLANK_CODE (10), ones=7 -> o_bin=7. Then ones=5 with no tens strobe -> o_bin=5, confirming tens cleared.
- tens=12, ones=3 -> o_bin=0, o_err=1. Next tens=1,ones=0 -> o_bin=10, o_err=0.
- Start 2,5. Pulse i_ones with i_dec=9 and i_tens at cycle 3 of CONV -> ignored; o_bin=25, exactly one o_valid. Also: i_tens and i_ones together in IDLE -> no conversion, tens captured.
- Start 3,8; assert i_reset_n=0 at cycle 4 -> outputs zero immediately, no o_valid. After release, 1,9 -> o_bin=19.
- Exhaustive sweep of all 256 {tens,ones} codes, checked against the reference model (value, saturation, error precedence: err over ovf).

Source files
------------

// File: rtl/dec2bin.sv
// Purpose: two-digit BCD (tens, ones) to 6-bit binary via reverse double-dabble, saturating at 63.
// Latency: i_ones sampled at edge E0 -> o_valid pulse after edge E7 (7 shift cycles).
// Backpressure: none; i_tens/i_ones strobes are dropped while o_busy is high (no queueing).
module dec2bin #(
  parameter logic [3:0] BLANK_CODE = 4'd10
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_dec,
  input  logic       i_tens,
  input  logic       i_ones,
  output logic [5:0] o_bin,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_ovf,
  output logic       o_err
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_nxt;
  logic [3:0]  tens_q;
  logic        err_q;
  logic [14:0] sr_q;      // {tens bcd, ones bcd, bin[6:0]}
  logic [2:0]  cnt_q;

  logic [3:0]  dig_val;
  logic        dig_bad;
  logic [14:0] sr_shift;
  logic [14:0] sr_adj;
  logic        capture_tens;
  logic        start;
  logic        last;

  // Sanitise the incoming digit: blank and invalid codes both load as zero.
  always_comb begin
    dig_bad = (i_dec > 4'd9) && (i_dec != BLANK_CODE);
    dig_val = (dig_bad || (i_dec == BLANK_CODE)) ? 4'd0 : i_dec;
  end

  // One reverse double-dabble step: shift right, then pull each BCD nibble >= 8 back by 3.
  always_comb begin
    sr_shift = {1'b0, sr_q[14:1]};
    sr_adj   = sr_shift;
    if (sr_shift[14:11] >= 4'd8) sr_adj[14:11] = sr_shift[14:11] - 4'd3;
    if (sr_shift[10:7]  >= 4'd8) sr_adj[10:7]  = sr_shift[10:7]  - 4'd3;
  end

  // Strobe qualification; tens wins over ones when both arrive together.
  always_comb begin
    capture_tens = (state == IDLE) && i_tens;
    start        = (state == IDLE) && i_ones && !i_tens;
    last         = (state == CONV) && (cnt_q == 3'd6);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state: leave IDLE on a ones strobe, return after the seventh shift.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digit capture, shifting datapath and registered result/status outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tens_q  <= 4'd0;
      err_q   <= 1'b0;
      sr_q    <= 15'd0;
      cnt_q   <= 3'd0;
      o_bin   <= 6'd0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (capture_tens) begin
        tens_q <= dig_val;
        err_q  <= err_q | dig_bad;
      end else if (start) begin
        sr_q   <= {tens_q, dig_val, 7'd0};
        err_q  <= err_q | dig_bad;
        cnt_q  <= 3'd0;
        o_busy <= 1'b1;
      end else if (state == CONV) begin
        sr_q  <= sr_adj;
        cnt_q <= cnt_q + 3'd1;
        if (last) begin
          o_busy  <= 1'b0;
          o_valid <= 1'b1;
          cnt_q   <= 3'd0;
          tens_q  <= 4'd0;
          err_q   <= 1'b0;
          // An invalid digit outranks saturation.
          if (err_q) begin
            o_bin <= 6'd0;
            o_err <= 1'b1;
            o_ovf <= 1'b0;
          end else if (sr_adj[6]) begin
            o_bin <= 6'd63;
            o_err <= 1'b0;
            o_ovf <= 1'b1;
          end else begin
            o_bin <= sr_adj[5:0];
            o_err <= 1'b0;
            o_ovf <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dec2bin.sv
// Purpose: scoreboard bench for dec2bin; stimulus pushes expected results, monitor pops on o_valid.
// Latency: expects o_busy for 7 cycles and one o_valid pulse per accepted conversion.
// Backpressure: strobes during o_busy are issued deliberately and must produce nothing.
module tb_dec2bin;

  typedef struct packed {
    logic [5:0] bin;
    logic       ovf;
    logic       err;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [3:0] i_dec = 4'd0;
  logic       i_tens = 1'b0;
  logic       i_ones = 1'b0;
  logic [5:0] o_bin;
  logic       o_valid;
  logic       o_busy;
  logic       o_ovf;
  logic       o_err;

  int   checks = 0;
  int   failures = 0;
  int   pushed = 0;
  int   valids = 0;
  exp_t sb[$];

  dec2bin dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_dec     (i_dec),
    .i_tens    (i_tens),
    .i_ones    (i_ones),
    .o_bin     (o_bin),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_ovf     (o_ovf),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: blank counts as 0, any 11-15 digit is an error, >63 saturates.
  function automatic exp_t model(input int t, input int o);
    exp_t e;
    int   v;
    e = '0;
    if (t > 10 || o > 10) begin
      e.err = 1'b1;
    end else begin
      v = ((t == 10) ? 0 : t) * 10 + ((o == 10) ? 0 : o);
      if (v > 63) begin
        e.bin = 6'd63;
        e.ovf = 1'b1;
      end else begin
        e.bin = v[5:0];
      end
    end
    return e;
  endfunction

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (i_reset_n && o_valid) begin
      exp_t e;
      valids++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got bin=%0d with empty scoreboard", o_bin);
      end else begin
        e = sb.pop_front();
        check("bin", int'(o_bin), int'(e.bin));
        check("ovf", int'(o_ovf), int'(e.ovf));
        check("err", int'(o_err), int'(e.err));
        check("bcd_residue", int'(dut.sr_q[14:7]), 0);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_tens(input int d);
    i_dec  = 4'(d);
    i_tens = 1'b1;
    tick();
    i_tens = 1'b0;
  endtask

  task automatic send_ones(input int d, input exp_t e);
    sb.push_back(e);
    pushed++;
    i_dec  = 4'(d);
    i_ones = 1'b1;
    tick();
    i_ones = 1'b0;
  endtask

  // Bounded wait for o_busy to drop, then one more cycle so the monitor sees o_valid.
  task automatic wait_done(output int n);
    n = 0;
    while (o_busy && n < 20) begin
      n++;
      tick();
    end
    if (o_busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout got busy=1 after %0d cycles expected=0", n);
    end
    tick();
  endtask

  task automatic convert(input int t, input int o, input exp_t e);
    int n;
    send_tens(t);
    send_ones(o, e);
    wait_done(n);
  endtask

  initial begin
    int   n;
    exp_t e;

    #2;
    check("rst_bin", int'(o_bin), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ovf", int'(o_ovf), 0);
    check("rst_err", int'(o_err), 0);
    tick();
    i_reset_n = 1'b1;
    tick();

    // 42 with busy-length measurement.
    send_tens(4);
    e = '{bin: 6'd42, ovf: 1'b0, err: 1'b0};
    send_ones(2, e);
    wait_done(n);
    check("busy_cycles", n, 7);

    // Saturation boundary.
    convert(6, 3, '{bin: 6'd63, ovf: 1'b0, err: 1'b0});
    convert(6, 4, '{bin: 6'd63, ovf: 1'b1, err: 1'b0});
    convert(9, 9, '{bin: 6'd63, ovf: 1'b1, err: 1'b0});

    // Blank tens, then ones-only entry confirms tens was cleared.
    convert(10, 7, '{bin: 6'd7, ovf: 1'b0, err: 1'b0});
    send_ones(5, '{bin: 6'd5, ovf: 1'b0, err: 1'b0});
    wait_done(n);

    // Invalid tens, then error flag cleared for the next value.
    convert(12, 3, '{bin: 6'd0, ovf: 1'b0, err: 1'b1});
    convert(1, 0, '{bin: 6'd10, ovf: 1'b0, err: 1'b0});

    // Strobes during CONV are ignored.
    send_tens(2);
    send_ones(5, '{bin: 6'd25, ovf: 1'b0, err: 1'b0});
    tick();
    tick();
    i_dec  = 4'd9;
    i_tens = 1'b1;
    i_ones = 1'b1;
    tick();
    i_tens = 1'b0;
    i_ones = 1'b0;
    wait_done(n);
    tick();
    check("ignored_no_extra_valid", valids, pushed);

    // Simultaneous tens+ones in IDLE: tens captured, no conversion.
    i_dec  = 4'd7;
    i_tens = 1'b1;
    i_ones = 1'b1;
    tick();
    i_tens = 1'b0;
    i_ones = 1'b0;
    check("both_no_busy", int'(o_busy), 0);
    tick();
    check("both_no_busy_later", int'(o_busy), 0);
    send_ones(4, '{bin: 6'd63, ovf: 1'b1, err: 1'b0});
    wait_done(n);

    // Reset in the middle of a conversion aborts with no o_valid.
    send_tens(3);
    i_dec  = 4'd8;
    i_ones = 1'b1;
    tick();
    i_ones = 1'b0;
    repeat (3) tick();
    i_reset_n = 1'b0;
    #1;
    check("abort_bin", int'(o_bin), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_valid", int'(o_valid), 0);
    tick();
    i_reset_n = 1'b1;
    repeat (10) tick();
    check("abort_no_valid", valids, pushed);
    convert(1, 9, '{bin: 6'd19, ovf: 1'b0, err: 1'b0});

    // Full code sweep against the model.
    for (int t = 0; t < 16; t++) begin
      for (int o = 0; o < 16; o++) begin
        convert(t, o, model(t, o));
      end
    end

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    check("valid_count", valids, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
